// File: rtl/sort_check_pkg.sv
// Shared types and constants for the sort_check_sink packet checker.
// Holds the FSM state encoding, LFSR seed/taps and the packet-counter width.
package sort_check_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Fibonacci taps 8,6,5,4 mapped onto state bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;
  localparam int unsigned PKT_CNT_W = 16;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sort_check_sink_lfsr8.sv
// lfsr8: free-running 8-bit Fibonacci LFSR, loaded with seed on reset.
// Used as the pseudo-random ready source when SORT_CHECK_BP_EN is defined.
module lfsr8
  import sort_check_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] seed,
  output logic [7:0] out
);

  logic [7:0] state_q;
  logic [7:0] state_d;

  always_comb begin
    state_d = lfsr_next(state_q);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= seed;
    end else begin
      state_q <= state_d;
    end
  end

  assign out = state_q;

endmodule

// File: rtl/sort_check_sink.sv
// sort_check_sink: Avalon-ST sink checking packet length, ascending order and framing.
// Define SORT_CHECK_BP_EN to drive snk_ready_o from an LFSR for backpressure.
module sort_check_sink
  import sort_check_pkg::*;
#(
  parameter  int DWIDTH      = 8,
  parameter  int MAX_PKT_LEN = 1024,
  localparam int LEN_W       = $clog2(MAX_PKT_LEN + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [DWIDTH-1:0]    snk_data_i,
  input  logic                 snk_startofpacket_i,
  input  logic                 snk_endofpacket_i,
  input  logic                 snk_valid_i,
  output logic                 snk_ready_o,
  output logic                 done_o,
  output logic [LEN_W-1:0]     pkt_len_o,
  output logic                 order_err_o,
  output logic                 framing_err_o,
  output logic [PKT_CNT_W-1:0] pkt_cnt_o
);

  state_t                 state_q, state_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [DWIDTH-1:0]      prev_q, prev_d;
  logic                   ord_q, ord_d;
  logic                   ready_q, ready_d;
  logic                   done_q, done_d;
  logic [LEN_W-1:0]       pkt_len_q, pkt_len_d;
  logic                   order_err_q, order_err_d;
  logic                   framing_q, framing_d;
  logic [PKT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   beat;
  logic                   desc;

`ifdef SORT_CHECK_BP_EN
  logic [7:0] lfsr_state;

  lfsr8 u_lfsr (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .seed    (LFSR_SEED),
    .out     (lfsr_state)
  );
`endif

  assign beat = snk_valid_i & ready_q;
  assign desc = snk_data_i < prev_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    prev_d      = prev_q;
    ord_d       = ord_q;
    done_d      = 1'b0;
    pkt_len_d   = pkt_len_q;
    order_err_d = order_err_q;
    framing_d   = framing_q;
    cnt_d       = cnt_q;
`ifdef SORT_CHECK_BP_EN
    ready_d     = lfsr_state[0];
`else
    ready_d     = 1'b1;
`endif

    if (beat) begin
      if (snk_startofpacket_i) begin
        // A sop inside RECV abandons the partial packet and restarts here.
        if (state_q == RECV) framing_d = 1'b1;
        len_d  = LEN_W'(1);
        prev_d = snk_data_i;
        ord_d  = 1'b0;
        if (snk_endofpacket_i) begin
          state_d     = IDLE;
          done_d      = 1'b1;
          pkt_len_d   = LEN_W'(1);
          order_err_d = 1'b0;
          cnt_d       = cnt_q + PKT_CNT_W'(1);
        end else begin
          state_d = RECV;
        end
      end else if (state_q == IDLE) begin
        framing_d = 1'b1;
      end else if ((len_q == LEN_W'(MAX_PKT_LEN)) && !snk_endofpacket_i) begin
        framing_d = 1'b1;
        state_d   = IDLE;
      end else begin
        ord_d  = ord_q | desc;
        prev_d = snk_data_i;
        len_d  = len_q + LEN_W'(1);
        if (snk_endofpacket_i) begin
          state_d     = IDLE;
          done_d      = 1'b1;
          pkt_len_d   = len_q + LEN_W'(1);
          order_err_d = ord_q | desc;
          cnt_d       = cnt_q + PKT_CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      len_q       <= '0;
      prev_q      <= '0;
      ord_q       <= 1'b0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      pkt_len_q   <= '0;
      order_err_q <= 1'b0;
      framing_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      prev_q      <= prev_d;
      ord_q       <= ord_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      pkt_len_q   <= pkt_len_d;
      order_err_q <= order_err_d;
      framing_q   <= framing_d;
      cnt_q       <= cnt_d;
    end
  end

  assign snk_ready_o   = ready_q;
  assign done_o        = done_q;
  assign pkt_len_o     = pkt_len_q;
  assign order_err_o   = order_err_q;
  assign framing_err_o = framing_q;
  assign pkt_cnt_o     = cnt_q;

endmodule
